// File: rtl/parity_pkg.sv
// Shared constants for the parity round-robin scheduler: parity sense,
// request mode encoding and the response-slot FSM states.
package parity_pkg;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam logic MODE_GEN = 1'b0;
    localparam logic MODE_CHK = 1'b1;

    // Response slot occupancy: EMPTY means rsp_valid is low, FULL means high.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } slot_state_t;

endpackage : parity_pkg

// File: rtl/parity_rr_scheduler_if.sv
// Request/response bundle between the requesters (master side) and the
// parity scheduler (slave side).
interface parity_rr_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_mode;
    logic [NUM_REQ-1:0]        req_par;
    logic [NUM_REQ-1:0]        req_ready;

    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [ID_W-1:0]           rsp_id;
    logic                      rsp_parity;
    logic                      rsp_error;

    // Requester / response consumer side.
    modport master (
        output req_valid, req_data, req_mode, req_par, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_parity, rsp_error
    );

    // Scheduler side.
    modport slave (
        input  req_valid, req_data, req_mode, req_par, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_parity, rsp_error
    );

endinterface : parity_rr_scheduler_if

// File: rtl/parity_core.sv
// Combinational parity engine: XOR reduction of the data word, inverted
// when odd parity is selected.
module parity_core
    import parity_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ODD_PARITY = 0
) (
    input  logic [DATA_W-1:0] data,
    output logic              parity
);

    localparam logic PAR_SEL = (ODD_PARITY != 0) ? PAR_ODD : PAR_EVEN;

    // Even parity bit is the plain reduction; odd flips it.
    always_comb begin
        parity = (^data) ^ PAR_SEL;
    end

endmodule : parity_core

// File: rtl/parity_rr_scheduler.sv
// Shares one parity engine among NUM_REQ requesters with round-robin
// arbitration, returns a single registered response per accept and keeps a
// saturating count of failed parity checks.
module parity_rr_scheduler
    import parity_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_W     = 8,
    parameter int ODD_PARITY = 0,
    parameter int ERR_CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    parity_rr_scheduler_if.slave  bus,
    input  logic                  err_clr,
    output logic [ERR_CNT_W-1:0]  err_count
);

    localparam int                ID_W      = $clog2(NUM_REQ);
    localparam logic [ID_W:0]     NUM_REQ_W = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0]   LAST_IDX  = ID_W'(NUM_REQ - 1);

    slot_state_t           state_reg;
    logic                  rsp_valid_reg;
    logic [ID_W-1:0]       rsp_id_reg;
    logic                  rsp_parity_reg;
    logic                  rsp_error_reg;
    logic [ID_W-1:0]       ptr_reg;
    logic [ERR_CNT_W-1:0]  err_count_reg;

    logic                  grant_found;
    logic [ID_W-1:0]       grant_idx;
    logic [NUM_REQ-1:0]    grant_onehot;
    logic [ID_W:0]         cand;
    logic [ID_W-1:0]       ptr_next;

    logic                  slot_free;
    logic                  xfer;
    logic [DATA_W-1:0]     data_arr [NUM_REQ];
    logic [DATA_W-1:0]     sel_data;
    logic                  sel_mode;
    logic                  sel_par;
    logic                  par_bit;
    logic                  chk_err;

    // Split the flat data bus into one word per requester.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_data_split
            assign data_arr[gi] = bus.req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // A new response may be produced when the slot is empty or draining now.
    assign slot_free = !rsp_valid_reg || bus.rsp_ready;

    // Round-robin search starting at the pointer and wrapping past NUM_REQ-1.
    always_comb begin
        grant_found  = 1'b0;
        grant_idx    = '0;
        grant_onehot = '0;
        cand         = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr_reg} + (ID_W+1)'(k);
            if (cand >= NUM_REQ_W) begin
                cand = cand - NUM_REQ_W;
            end
            if (!grant_found && bus.req_valid[cand[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[ID_W-1:0];
            end
        end
        if (grant_found) begin
            grant_onehot = NUM_REQ'(1) << grant_idx;
        end
    end

    // Ready is held off during reset so nothing is accepted before release.
    assign bus.req_ready = (rst_n && slot_free) ? grant_onehot : '0;
    assign xfer          = rst_n && slot_free && grant_found;

    assign sel_data = data_arr[grant_idx];
    assign sel_mode = bus.req_mode[grant_idx];
    assign sel_par  = bus.req_par[grant_idx];

    parity_core #(
        .DATA_W     (DATA_W),
        .ODD_PARITY (ODD_PARITY)
    ) u_parity_core (
        .data   (sel_data),
        .parity (par_bit)
    );

    assign chk_err  = (sel_mode == MODE_CHK) && (par_bit != sel_par);
    assign ptr_next = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;

    // Response slot FSM: loads on every transfer, holds on stall, empties
    // when the consumer takes the response and nothing new is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_EMPTY;
            rsp_valid_reg  <= 1'b0;
            rsp_id_reg     <= '0;
            rsp_parity_reg <= 1'b0;
            rsp_error_reg  <= 1'b0;
            ptr_reg        <= '0;
        end else begin
            case (state_reg)
                ST_EMPTY: begin
                    if (xfer) begin
                        state_reg      <= ST_FULL;
                        rsp_valid_reg  <= 1'b1;
                        rsp_id_reg     <= grant_idx;
                        rsp_parity_reg <= par_bit;
                        rsp_error_reg  <= chk_err;
                        ptr_reg        <= ptr_next;
                    end
                end
                ST_FULL: begin
                    if (xfer) begin
                        rsp_valid_reg  <= 1'b1;
                        rsp_id_reg     <= grant_idx;
                        rsp_parity_reg <= par_bit;
                        rsp_error_reg  <= chk_err;
                        ptr_reg        <= ptr_next;
                    end else if (bus.rsp_ready) begin
                        state_reg     <= ST_EMPTY;
                        rsp_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= ST_EMPTY;
                    rsp_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    // Saturating count of accepted check requests that failed; clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count_reg <= '0;
        end else if (err_clr) begin
            err_count_reg <= '0;
        end else if (xfer && chk_err && (err_count_reg != '1)) begin
            err_count_reg <= err_count_reg + 1'b1;
        end
    end

    assign bus.rsp_valid  = rsp_valid_reg;
    assign bus.rsp_id     = rsp_id_reg;
    assign bus.rsp_parity = rsp_parity_reg;
    assign bus.rsp_error  = rsp_error_reg;
    assign err_count      = err_count_reg;

endmodule : parity_rr_scheduler

// File: tb/tb_parity_rr_scheduler.sv
// Directed bench for parity_rr_scheduler. Three instances share one stimulus:
// even parity with a wide counter, odd parity, and a 2-bit counter.
module tb_parity_rr_scheduler;

    logic clk = 1'b0;
    logic rst_n;
    logic err_clr;
    logic [15:0] err_count_e;
    logic [15:0] err_count_o;
    logic [1:0]  err_count_s;

    int checks   = 0;
    int failures = 0;

    parity_rr_scheduler_if #(.NUM_REQ(4), .DATA_W(8)) if_e ();
    parity_rr_scheduler_if #(.NUM_REQ(4), .DATA_W(8)) if_o ();
    parity_rr_scheduler_if #(.NUM_REQ(4), .DATA_W(8)) if_s ();

    assign if_o.req_valid = if_e.req_valid;
    assign if_o.req_data  = if_e.req_data;
    assign if_o.req_mode  = if_e.req_mode;
    assign if_o.req_par   = if_e.req_par;
    assign if_o.rsp_ready = if_e.rsp_ready;
    assign if_s.req_valid = if_e.req_valid;
    assign if_s.req_data  = if_e.req_data;
    assign if_s.req_mode  = if_e.req_mode;
    assign if_s.req_par   = if_e.req_par;
    assign if_s.rsp_ready = if_e.rsp_ready;

    parity_rr_scheduler #(.NUM_REQ(4), .DATA_W(8), .ODD_PARITY(0), .ERR_CNT_W(16)) dut_e (
        .clk(clk), .rst_n(rst_n), .bus(if_e), .err_clr(err_clr), .err_count(err_count_e));
    parity_rr_scheduler #(.NUM_REQ(4), .DATA_W(8), .ODD_PARITY(1), .ERR_CNT_W(16)) dut_o (
        .clk(clk), .rst_n(rst_n), .bus(if_o), .err_clr(err_clr), .err_count(err_count_o));
    parity_rr_scheduler #(.NUM_REQ(4), .DATA_W(8), .ODD_PARITY(0), .ERR_CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .bus(if_s), .err_clr(err_clr), .err_count(err_count_s));

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [7:0] d, input logic m, input logic p);
        if_e.req_data[i*8 +: 8] = d;
        if_e.req_mode[i]        = m;
        if_e.req_par[i]         = p;
    endtask

    logic [7:0] t5_data [4];
    logic       t5_par  [4];

    initial begin
        rst_n          = 1'b0;
        err_clr        = 1'b0;
        if_e.req_valid = 4'b1111;
        if_e.req_data  = '0;
        if_e.req_mode  = '0;
        if_e.req_par   = '0;
        if_e.rsp_ready = 1'b1;

        // 1. Reset state with all requesters valid
        tick();
        tick();
        check_eq("rst_req_ready", if_e.req_ready, 4'b0000);
        check_eq("rst_rsp_valid", if_e.rsp_valid, 1'b0);
        check_eq("rst_rsp_id", if_e.rsp_id, 2'd0);
        check_eq("rst_err_count", err_count_e, 16'd0);
        rst_n = 1'b1;
        #1;
        check_eq("rel_first_grant", if_e.req_ready, 4'b0001);

        // 2. Round-robin over all four requesters
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("rr_ready_%0d", i), if_e.req_ready, 4'b0001 << (i % 4));
            tick();
            check_eq($sformatf("rr_valid_%0d", i), if_e.rsp_valid, 1'b1);
            check_eq($sformatf("rr_id_%0d", i), if_e.rsp_id, i % 4);
        end

        // 3. Generate mode, sole requester 0
        if_e.req_valid = 4'b0001;
        set_req(0, 8'hA5, 1'b0, 1'b0);
        #1;
        check_eq("gen_sole_ready", if_e.req_ready, 4'b0001);
        tick();
        check_eq("gen_a5_even", if_e.rsp_parity, 1'b0);
        check_eq("gen_a5_odd", if_o.rsp_parity, 1'b1);
        check_eq("gen_a5_err", if_e.rsp_error, 1'b0);
        set_req(0, 8'h07, 1'b0, 1'b0);
        #1;
        check_eq("gen_sole_regrant", if_e.req_ready, 4'b0001);
        tick();
        check_eq("gen_07_even", if_e.rsp_parity, 1'b1);
        check_eq("gen_07_odd", if_o.rsp_parity, 1'b0);
        check_eq("gen_07_err_odd", if_o.rsp_error, 1'b0);

        // 4. Check mode from requester 2
        if_e.req_valid = 4'b0100;
        set_req(2, 8'h01, 1'b1, 1'b0);
        tick();
        check_eq("chk_id", if_e.rsp_id, 2'd2);
        check_eq("chk_err_even", if_e.rsp_error, 1'b1);
        check_eq("chk_cnt_even", err_count_e, 16'd1);
        check_eq("chk_err_odd", if_o.rsp_error, 1'b0);
        check_eq("chk_cnt_odd", err_count_o, 16'd0);
        set_req(2, 8'h01, 1'b1, 1'b1);
        tick();
        check_eq("chk_ok_err", if_e.rsp_error, 1'b0);
        check_eq("chk_ok_cnt", err_count_e, 16'd1);
        check_eq("chk_ok_odd_err", if_o.rsp_error, 1'b1);

        // 5. Backpressure: response (id 2, parity 1) must hold for 5 cycles
        t5_data[0] = 8'h00; t5_par[0] = 1'b0;
        t5_data[1] = 8'h01; t5_par[1] = 1'b1;
        t5_data[2] = 8'h03; t5_par[2] = 1'b0;
        t5_data[3] = 8'h07; t5_par[3] = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, t5_data[i], 1'b0, 1'b0);
        if_e.req_valid = 4'b1111;
        if_e.rsp_ready = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("bp_ready_%0d", i), if_e.req_ready, 4'b0000);
            tick();
            check_eq($sformatf("bp_valid_%0d", i), if_e.rsp_valid, 1'b1);
            check_eq($sformatf("bp_id_%0d", i), if_e.rsp_id, 2'd2);
            check_eq($sformatf("bp_par_%0d", i), if_e.rsp_parity, 1'b1);
            check_eq($sformatf("bp_err_%0d", i), if_e.rsp_error, 1'b0);
        end
        if_e.rsp_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            int exp_id;
            exp_id = (3 + i) % 4;
            check_eq($sformatf("bp_rel_ready_%0d", i), if_e.req_ready, 4'b0001 << exp_id);
            tick();
            check_eq($sformatf("bp_rel_id_%0d", i), if_e.rsp_id, exp_id);
            check_eq($sformatf("bp_rel_par_%0d", i), if_e.rsp_parity, t5_par[exp_id]);
        end
        if_e.req_valid = 4'b0000;
        tick();
        check_eq("idle_clear", if_e.rsp_valid, 1'b0);

        // 6. Counter clear, saturation and clear-wins
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check_eq("clr_cnt_even", err_count_e, 16'd0);
        check_eq("clr_cnt_sat", err_count_s, 2'd0);
        if_e.req_valid = 4'b0001;
        set_req(0, 8'h01, 1'b1, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            check_eq($sformatf("sat_cnt_%0d", k), err_count_s, (k > 3) ? 3 : k);
            check_eq($sformatf("wide_cnt_%0d", k), err_count_e, k);
        end
        check_eq("sat_odd_cnt", err_count_o, 16'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check_eq("clrwin_err", if_e.rsp_error, 1'b1);
        check_eq("clrwin_cnt_even", err_count_e, 16'd0);
        check_eq("clrwin_cnt_sat", err_count_s, 2'd0);

        // Reset while a response is pending
        check_eq("pre_rst_valid", if_e.rsp_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_valid", if_e.rsp_valid, 1'b0);
        check_eq("midrst_ready", if_e.req_ready, 4'b0000);
        if_e.req_valid = 4'b0000;
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("post_rst_valid", if_e.rsp_valid, 1'b0);
        if_e.req_valid = 4'b1001;
        #1;
        check_eq("post_rst_ptr", if_e.req_ready, 4'b0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_parity_rr_scheduler
